mem_arbiter: RTL and testbench

Shares the single byte-wide main-memory port between the Icache refill path (instruction words requested on behalf of cpu_if) and the load/store path.
- Sequences multi-byte transfers one byte per cycle, little-endian.
- Arbitrates round-robin between the two requesters.
- Stalls IO writes while the IO buffer is full.
- Sits between the Icache/LSB and the top-level RAM/IO interface.

---
 rtl/mem_arbiter_pkg.sv | 32 +++
 rtl/mem_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared widths, size codes, state encodings and defaults for the byte-serial
// main-memory arbiter.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEFAULT = 32;
    localparam int WORD_W         = 32;

    localparam logic [1:0] IO_SEL_DEFAULT = 2'b11;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_IC_RD = 2'd1;
    localparam logic [1:0] ST_LS_RD = 2'd2;
    localparam logic [1:0] ST_LS_WR = 2'd3;

    localparam logic GRANT_IC = 1'b0;
    localparam logic GRANT_LS = 1'b1;

    // Index of the final byte of an LS transfer; the illegal code 3 behaves as a word.
    function automatic logic [1:0] size_last_idx(input logic [1:0] size);
        case (size)
            SZ_B:    return 2'd0;
            SZ_H:    return 2'd1;
            SZ_W:    return 2'd3;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the byte-wide memory port between Icache refills
// and the load/store path; transfers are sequenced one byte per cycle, little-endian.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter logic [1:0] IO_SEL = IO_SEL_DEFAULT,
    parameter int         ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_done,
    output logic [WORD_W-1:0] ic_data,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [WORD_W-1:0] ls_wdata,
    output logic              ls_done,
    output logic [WORD_W-1:0] ls_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full,
    output logic [1:0]        dbg_state
);

    logic [1:0]        state_q,      state_d;
    logic [1:0]        cnt_q,        cnt_d;
    logic [1:0]        last_idx_q,   last_idx_d;
    logic [ADDR_W-1:0] base_q,       base_d;
    logic [WORD_W-1:0] wdata_q,      wdata_d;
    logic [WORD_W-1:0] buf_q,        buf_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] mem_a_q,      mem_a_d;
    logic [7:0]        mem_dout_q,   mem_dout_d;
    logic              mem_wr_q,     mem_wr_d;
    logic              ic_done_q,    ic_done_d;
    logic              ls_done_q,    ls_done_d;
    logic [WORD_W-1:0] ic_data_q,    ic_data_d;
    logic [WORD_W-1:0] ls_rdata_q,   ls_rdata_d;

    logic              ic_elig;
    logic              ls_elig;
    logic              grant_ic;
    logic              grant_ls;
    logic [1:0]        cnt_nxt;
    logic [WORD_W-1:0] buf_asm;

    // An IO store cannot start while the IO buffer is full; IC may use the port meanwhile.
    always_comb begin
        ic_elig  = ic_req;
        ls_elig  = ls_req && !(ls_we && (ls_addr[17:16] == IO_SEL) && io_buffer_full);
        grant_ls = ls_elig && (!ic_elig || (last_grant_q == GRANT_IC));
        grant_ic = ic_elig && !grant_ls;
    end

    always_comb begin
        cnt_nxt = cnt_q + 2'd1;
        buf_asm = buf_q;
        buf_asm[{cnt_q, 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_idx_d   = last_idx_q;
        base_d       = base_q;
        wdata_d      = wdata_q;
        buf_d        = buf_q;
        last_grant_d = last_grant_q;
        mem_a_d      = mem_a_q;
        mem_dout_d   = mem_dout_q;
        mem_wr_d     = mem_wr_q;
        ic_done_d    = 1'b0;
        ls_done_d    = 1'b0;
        ic_data_d    = ic_data_q;
        ls_rdata_d   = ls_rdata_q;

        if (!rdy) begin
            // Frozen cycle: the byte on the bus is not committed and is replayed later.
            mem_wr_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_ic) begin
                        state_d      = ST_IC_RD;
                        last_grant_d = GRANT_IC;
                        base_d       = ic_addr;
                        last_idx_d   = 2'd3;
                        cnt_d        = 2'd0;
                        buf_d        = '0;
                        mem_a_d      = ic_addr;
                        mem_wr_d     = 1'b0;
                    end else if (grant_ls) begin
                        state_d      = ls_we ? ST_LS_WR : ST_LS_RD;
                        last_grant_d = GRANT_LS;
                        base_d       = ls_addr;
                        wdata_d      = ls_wdata;
                        last_idx_d   = size_last_idx(ls_size);
                        cnt_d        = 2'd0;
                        buf_d        = '0;
                        mem_a_d      = ls_addr;
                        mem_dout_d   = ls_wdata[7:0];
                        mem_wr_d     = ls_we;
                    end
                end
                ST_IC_RD, ST_LS_RD: begin
                    if ((state_q == ST_IC_RD) && !ic_req) begin
                        state_d = ST_IDLE;
                    end else begin
                        buf_d = buf_asm;
                        if (cnt_q == last_idx_q) begin
                            state_d = ST_IDLE;
                            if (state_q == ST_IC_RD) begin
                                ic_done_d = 1'b1;
                                ic_data_d = buf_asm;
                            end else begin
                                ls_done_d  = 1'b1;
                                ls_rdata_d = buf_asm;
                            end
                        end else begin
                            cnt_d   = cnt_nxt;
                            mem_a_d = base_q + ADDR_W'(cnt_nxt);
                        end
                    end
                end
                ST_LS_WR: begin
                    if (!mem_wr_q) begin
                        mem_wr_d = 1'b1;
                    end else if (cnt_q == last_idx_q) begin
                        mem_wr_d  = 1'b0;
                        ls_done_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        cnt_d      = cnt_nxt;
                        mem_a_d    = base_q + ADDR_W'(cnt_nxt);
                        mem_dout_d = wdata_q[{cnt_nxt, 3'b000} +: 8];
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    mem_wr_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_idx_q   <= '0;
            base_q       <= '0;
            wdata_q      <= '0;
            buf_q        <= '0;
            last_grant_q <= GRANT_IC;
            mem_a_q      <= '0;
            mem_dout_q   <= '0;
            mem_wr_q     <= 1'b0;
            ic_done_q    <= 1'b0;
            ls_done_q    <= 1'b0;
            ic_data_q    <= '0;
            ls_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_idx_q   <= last_idx_d;
            base_q       <= base_d;
            wdata_q      <= wdata_d;
            buf_q        <= buf_d;
            last_grant_q <= last_grant_d;
            mem_a_q      <= mem_a_d;
            mem_dout_q   <= mem_dout_d;
            mem_wr_q     <= mem_wr_d;
            ic_done_q    <= ic_done_d;
            ls_done_q    <= ls_done_d;
            ic_data_q    <= ic_data_d;
            ls_rdata_q   <= ls_rdata_d;
        end
    end

    assign ic_done   = ic_done_q;
    assign ic_data   = ic_data_q;
    assign ls_done   = ls_done_q;
    assign ls_rdata  = ls_rdata_q;
    assign mem_a     = mem_a_q;
    assign mem_dout  = mem_dout_q;
    assign mem_wr    = mem_wr_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed timing scenarios plus a randomized phase
// checked against a byte-addressed memory model and a write scoreboard.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_done;
    logic [31:0] ic_data;
    logic        ls_req;
    logic        ls_we;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;
    logic [1:0]  dbg_state;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [39:0] exp_q[$];
    logic [7:0]  wmem[logic [31:0]];
    logic [39:0] mon_w;
    logic        rdy_at_edge;
    logic        ic_done_prev = 1'b0;
    logic        ls_done_prev = 1'b0;
    bit          rand_stop;

    mem_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_data(ic_data),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ic_req = 1'b0; ls_req = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
        ic_addr = '0; ls_addr = '0; ls_we = 1'b0; ls_size = SZ_B; ls_wdata = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- memory model ----------------
    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (wmem.exists(a)) return wmem[a];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
    endfunction

    function automatic int sz_len(input logic [1:0] s);
        if (s == 2'd0) return 1;
        if (s == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a, input int n);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = rd_byte(a + 32'(i));
        return v;
    endfunction

    // Read data is valid during the cycle after the address is presented.
    always @(negedge clk) mem_din <= rd_byte(mem_a);

    // Committed writes: mem_wr high at an edge where rdy is high.
    always @(posedge clk) begin
        if (!rst && rdy && mem_wr) begin
            wmem[mem_a] = mem_dout;
            check("write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_w = exp_q.pop_front();
                check("write_addr_data", {24'd0, mem_a, mem_dout}, {24'd0, mon_w});
            end
        end
    end

    always @(posedge clk) begin
        rdy_at_edge = rdy;
        #1;
        if (ic_done) begin
            check("ic_done_width", 64'(ic_done_prev), 64'd0);
            check("ic_done_rdy", 64'(rdy_at_edge), 64'd1);
        end
        if (ls_done) begin
            check("ls_done_width", 64'(ls_done_prev), 64'd0);
            check("ls_done_rdy", 64'(rdy_at_edge), 64'd1);
        end
        ic_done_prev = ic_done;
        ls_done_prev = ls_done;
    end

    // ---------------- drivers ----------------
    task automatic ic_read(input logic [31:0] a, input string tag);
        logic [31:0] expv;
        bit seen;
        expv = exp_read(a, 4);
        ic_addr = a; ic_req = 1'b1; seen = 1'b0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (ic_done) begin seen = 1'b1; break; end
        end
        ic_req = 1'b0;
        check({tag, "_done"}, 64'(seen), 64'd1);
        if (seen) check({tag, "_data"}, 64'(ic_data), 64'(expv));
    endtask

    task automatic ls_xfer(input logic we, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, input string tag);
        logic [31:0] expv;
        logic [31:0] old_rdata;
        bit seen;
        int n;
        n = sz_len(sz);
        expv = '0;
        old_rdata = ls_rdata;
        if (we) begin
            for (int i = 0; i < n; i++) exp_q.push_back({a + 32'(i), wd[8*i +: 8]});
        end else begin
            expv = exp_read(a, n);
        end
        ls_we = we; ls_size = sz; ls_addr = a; ls_wdata = wd; ls_req = 1'b1; seen = 1'b0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (ls_done) begin seen = 1'b1; break; end
        end
        ls_req = 1'b0;
        check({tag, "_done"}, 64'(seen), 64'd1);
        if (seen && !we) check({tag, "_rdata"}, 64'(ls_rdata), 64'(expv));
        if (seen && we) check({tag, "_rdata_hold"}, 64'(ls_rdata), 64'(old_rdata));
    endtask

    task automatic wait_ic_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (ic_done) begin seen = 1'b1; break; end
        end
        check(tag, 64'(seen), 64'd1);
    endtask

    task automatic ic_rand();
        logic [31:0] a;
        for (int i = 0; i < 12; i++) begin
            a = (i == 0) ? 32'hFFFF_FFFE : (32'h1000 | 32'($urandom_range(0, 4095)));
            ic_read(a, "rand_ic");
            repeat ($urandom_range(0, 3)) tick();
        end
    endtask

    task automatic ls_rand();
        logic [31:0] a;
        logic        we;
        logic [1:0]  sz;
        for (int i = 0; i < 20; i++) begin
            if (i == 0) begin
                we = 1'b0; sz = SZ_H; a = 32'hFFFF_FFFF;
            end else begin
                we = 1'($urandom_range(0, 1));
                sz = 2'($urandom_range(0, 3));
                a  = {14'd0, ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b10, 16'($urandom_range(0, 65535))};
            end
            ls_xfer(we, sz, a, $urandom, "rand_ls");
            repeat ($urandom_range(0, 3)) tick();
        end
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] saved;
    int          lat;

    initial begin
        rand_stop = 1'b0;
        do_reset();

        // Reset state
        check("rst_mem_a", 64'(mem_a), 64'd0);
        check("rst_mem_wr", 64'(mem_wr), 64'd0);
        check("rst_mem_dout", 64'(mem_dout), 64'd0);
        check("rst_done", 64'({ic_done, ls_done}), 64'd0);
        check("rst_data", {ic_data, ls_rdata}, 64'd0);
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));

        // IC refill of a known instruction word
        wmem[32'h1000] = 8'h13; wmem[32'h1001] = 8'h05;
        wmem[32'h1002] = 8'h00; wmem[32'h1003] = 8'h00;
        ic_addr = 32'h1000; ic_req = 1'b1;
        tick();
        for (int k = 1; k <= 4; k++) begin
            check("ic_mem_a", 64'(mem_a), 64'(32'h1000 + 32'(k - 1)));
            check("ic_mem_wr", 64'(mem_wr), 64'd0);
            check("ic_done_early", 64'(ic_done), 64'd0);
            tick();
        end
        check("ic_done_at_e4", 64'(ic_done), 64'd1);
        check("ic_word", 64'(ic_data), 64'h0000_0513);
        ic_req = 1'b0;
        tick();
        check("ic_done_drop", 64'(ic_done), 64'd0);

        // Halfword store
        saved = ls_rdata;
        exp_q.push_back({32'h20, 8'hDD});
        exp_q.push_back({32'h21, 8'hCC});
        ls_we = 1'b1; ls_size = SZ_H; ls_addr = 32'h20; ls_wdata = 32'hAABB_CCDD; ls_req = 1'b1;
        tick();
        check("st_b0", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h20, 8'hDD});
        tick();
        check("st_b1", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h21, 8'hCC});
        tick();
        check("st_end_wr", 64'(mem_wr), 64'd0);
        check("st_done", 64'(ls_done), 64'd1);
        check("st_rdata_hold", 64'(ls_rdata), 64'(saved));
        ls_req = 1'b0;
        tick();

        // Contention after reset: LS first, then IC, then LS again
        do_reset();
        ic_addr = 32'h1000; ic_req = 1'b1;
        ls_we = 1'b0; ls_size = SZ_B; ls_addr = 32'h40; ls_req = 1'b1;
        tick();
        check("rr_first_ls", 64'(dbg_state), 64'(ST_LS_RD));
        tick();
        check("rr_ls_done", 64'(ls_done), 64'd1);
        check("rr_ls_data", 64'(ls_rdata), 64'(exp_read(32'h40, 1)));
        ls_req = 1'b0;
        tick();
        check("rr_then_ic", 64'(dbg_state), 64'(ST_IC_RD));
        repeat (4) tick();
        check("rr_ic_done", 64'(ic_done), 64'd1);
        check("rr_ic_data", 64'(ic_data), 64'h0000_0513);
        ic_addr = 32'h1004; ls_addr = 32'h41; ls_req = 1'b1;
        tick();
        check("rr_second_ls", 64'(dbg_state), 64'(ST_LS_RD));
        tick();
        check("rr_ls2_done", 64'(ls_done), 64'd1);
        ls_req = 1'b0;
        wait_ic_done("rr_ic2_done");
        check("rr_ic2_data", 64'(ic_data), 64'(exp_read(32'h1004, 4)));
        ic_req = 1'b0;
        tick();

        // IO store held off by a full buffer while IC proceeds
        io_buffer_full = 1'b1;
        ls_we = 1'b1; ls_size = SZ_B; ls_addr = 32'h0003_0000; ls_wdata = 32'h0000_0077; ls_req = 1'b1;
        ic_addr = 32'h1008; ic_req = 1'b1;
        tick();
        check("io_ic_granted", 64'(dbg_state), 64'(ST_IC_RD));
        wait_ic_done("io_ic_done");
        check("io_ic_data", 64'(ic_data), 64'(exp_read(32'h1008, 4)));
        ic_req = 1'b0;
        tick();
        check("io_blocked", 64'(dbg_state), 64'(ST_IDLE));
        check("io_no_wr", 64'(mem_wr), 64'd0);
        exp_q.push_back({32'h0003_0000, 8'h77});
        io_buffer_full = 1'b0;
        tick();
        check("io_store", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h0003_0000, 8'h77});
        tick();
        check("io_done", 64'(ls_done), 64'd1);
        ls_req = 1'b0;
        tick();

        // IC abort after two bytes; pending LS load takes over
        ic_addr = 32'h2000; ic_req = 1'b1;
        tick();
        check("ab_ic_granted", 64'(dbg_state), 64'(ST_IC_RD));
        saved = ic_data;
        ls_we = 1'b0; ls_size = SZ_W; ls_addr = 32'h100; ls_req = 1'b1;
        repeat (2) tick();
        ic_req = 1'b0;
        tick();
        check("ab_idle", 64'(dbg_state), 64'(ST_IDLE));
        check("ab_no_done", 64'(ic_done), 64'd0);
        check("ab_data_hold", 64'(ic_data), 64'(saved));
        tick();
        check("ab_ls_granted", 64'(dbg_state), 64'(ST_LS_RD));
        for (int c = 0; c < 10 && !ls_done; c++) tick();
        check("ab_ls_done", 64'(ls_done), 64'd1);
        check("ab_ls_data", 64'(ls_rdata), 64'(exp_read(32'h100, 4)));
        ls_req = 1'b0;
        tick();

        // rdy stall in the middle of a word load
        ls_we = 1'b0; ls_size = SZ_W; ls_addr = 32'h200; ls_req = 1'b1;
        tick();
        tick();
        rdy = 1'b0;
        repeat (3) begin
            tick();
            check("stall_wr", 64'(mem_wr), 64'd0);
            check("stall_no_done", 64'(ls_done), 64'd0);
        end
        check("stall_mem_a", 64'(mem_a), 64'h201);
        rdy = 1'b1;
        lat = 4;
        while (!ls_done && lat < 20) begin tick(); lat++; end
        check("stall_latency", 64'(lat), 64'd7);
        check("stall_data", 64'(ls_rdata), 64'(exp_read(32'h200, 4)));
        ls_req = 1'b0;
        tick();

        // Async reset in the middle of a refill
        ic_addr = 32'h1000; ic_req = 1'b1;
        tick();
        tick();
        #3;
        rst = 1'b1;
        #1;
        check("arst_mem_a", 64'(mem_a), 64'd0);
        check("arst_state", 64'(dbg_state), 64'(ST_IDLE));
        check("arst_outs", {ic_done, ls_done, mem_wr}, 64'd0);
        check("arst_data", {ic_data, ls_rdata}, 64'd0);
        ic_req = 1'b0;
        tick();
        check("arst_no_done", 64'(ic_done), 64'd0);
        do_reset();

        // Randomized concurrent traffic with rdy and IO-full noise
        fork
            begin
                fork
                    ic_rand();
                    ls_rand();
                join
                rand_stop = 1'b1;
            end
            begin
                while (!rand_stop) begin
                    @(posedge clk);
                    #1;
                    rdy = ($urandom_range(0, 3) != 0);
                end
                rdy = 1'b1;
            end
            begin
                while (!rand_stop) begin
                    @(posedge clk);
                    #1;
                    io_buffer_full = ($urandom_range(0, 1) != 0);
                end
                io_buffer_full = 1'b0;
            end
        join
        repeat (4) tick();

        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
